// File: rtl/regfile_dump_if.sv
// Byte-stream handshake bundle (valid/ready) carrying dumped register bytes
// from regfile_dump to the debug/host link.
interface regfile_dump_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/regfile_dump.sv
// Debug read-out engine: walks register indices FIRST..LAST through a read-only
// register file op and streams each byte out. Optional macro: REGDUMP_CSUM_EN.
module regfile_dump #(
  parameter logic [3:0] FIRST = 4'd0,
  parameter logic [3:0] LAST  = 4'd3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [6:0]       op,
  input  logic [7:0]       DO,
  regfile_dump_if.master   bus,
  output logic             busy,
  output logic             done
);

`ifdef REGDUMP_CSUM_EN
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, SEND = 2'd2, CSUM = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, SEND = 2'd2} state_t;
`endif

  state_t      state_r, next_state_s;
  logic [3:0]  idx_r, idx_next_s;
  logic [6:0]  op_r;
  logic [7:0]  out_data_r, data_next_s;
  logic        out_valid_r, valid_next_s;
  logic        busy_r, done_r, done_next_s;
  logic        accept_s;
`ifdef REGDUMP_CSUM_EN
  logic [7:0]  csum_r, csum_next_s;
`endif

  assign accept_s      = out_valid_r & bus.out_ready;
  assign op            = op_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_valid = out_valid_r;
  assign busy          = busy_r;
  assign done          = done_r;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    next_state_s = state_r;
    idx_next_s   = idx_r;
    data_next_s  = out_data_r;
    valid_next_s = out_valid_r;
    done_next_s  = 1'b0;
`ifdef REGDUMP_CSUM_EN
    csum_next_s  = csum_r;
`endif
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = READ;
          idx_next_s   = FIRST;
`ifdef REGDUMP_CSUM_EN
          csum_next_s  = 8'h00;
`endif
        end else begin
          next_state_s = IDLE;
        end
      end
      READ: begin
        // op has been stable for this whole cycle, so DO is settled here
        data_next_s  = DO;
        valid_next_s = 1'b1;
`ifdef REGDUMP_CSUM_EN
        csum_next_s  = csum_r ^ DO;
`endif
        next_state_s = SEND;
      end
      SEND: begin
        if (accept_s) begin
          valid_next_s = 1'b0;
          if (idx_r != LAST) begin
            idx_next_s   = idx_r + 4'd1;
            next_state_s = READ;
          end else begin
`ifdef REGDUMP_CSUM_EN
            next_state_s = CSUM;
            data_next_s  = csum_r;
            valid_next_s = 1'b1;
`else
            next_state_s = IDLE;
            idx_next_s   = FIRST;
            done_next_s  = 1'b1;
`endif
          end
        end else begin
          next_state_s = SEND;
        end
      end
`ifdef REGDUMP_CSUM_EN
      CSUM: begin
        if (accept_s) begin
          valid_next_s = 1'b0;
          next_state_s = IDLE;
          idx_next_s   = FIRST;
          done_next_s  = 1'b1;
        end else begin
          next_state_s = CSUM;
        end
      end
`endif
      default: begin
        next_state_s = IDLE;
        idx_next_s   = FIRST;
        valid_next_s = 1'b0;
      end
    endcase
  end

  // Registered datapath and outputs; op mirrors idx with write controls tied off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r       <= FIRST;
      op_r        <= {3'b000, FIRST};
      out_data_r  <= 8'h00;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      idx_r       <= idx_next_s;
      op_r        <= {3'b000, idx_next_s};
      out_data_r  <= data_next_s;
      out_valid_r <= valid_next_s;
      busy_r      <= (next_state_s != IDLE);
      done_r      <= done_next_s;
    end
  end

`ifdef REGDUMP_CSUM_EN
  // Running XOR of every byte read so far
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_r <= 8'h00;
    end else begin
      csum_r <= csum_next_s;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: two instances (default range and 5..10)
// share a behavioural register file; expected byte streams come from that array.
module tb_regfile_dump;

  logic       clk;
  logic       rst_n;
  logic       start_s [2];
  logic       ready_s [2];
  logic [7:0] regs [16];
  logic [6:0] op0, op1;
  logic       busy0, busy1, done0, done1;
  logic [7:0] obs_data  [2];
  logic       obs_valid [2];
  logic       obs_busy  [2];
  logic       obs_done  [2];
  logic [6:0] obs_op    [2];
  int checks;
  int errors;

  regfile_dump_if if0();
  regfile_dump_if if1();

  assign if0.out_ready = ready_s[0];
  assign if1.out_ready = ready_s[1];

  regfile_dump u0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .op(op0), .DO(regs[op0[3:0]]),
    .bus(if0.master), .busy(busy0), .done(done0)
  );

  regfile_dump #(.FIRST(4'd5), .LAST(4'd10)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .op(op1), .DO(regs[op1[3:0]]),
    .bus(if1.master), .busy(busy1), .done(done1)
  );

  assign obs_data[0]  = if0.out_data;
  assign obs_data[1]  = if1.out_data;
  assign obs_valid[0] = if0.out_valid;
  assign obs_valid[1] = if1.out_valid;
  assign obs_busy[0]  = busy0;
  assign obs_busy[1]  = busy1;
  assign obs_done[0]  = done0;
  assign obs_done[1]  = done1;
  assign obs_op[0]    = op0;
  assign obs_op[1]    = op1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int first_of(input int u);
    return (u == 0) ? 0 : 5;
  endfunction

  function automatic int last_of(input int u);
    return (u == 0) ? 3 : 10;
  endfunction

  task automatic init_regs();
    for (int i = 0; i < 16; i++) regs[i] = 8'h00;
    regs[0] = 8'h02; regs[1] = 8'h03; regs[2] = 8'h41; regs[3] = 8'hFF;
    regs[4] = 8'h5A;
    regs[5] = 8'h01; regs[6] = 8'hFF; regs[7] = 8'h00;
    regs[8] = 8'hF9; regs[9] = 8'hFB; regs[10] = 8'hFD;
  endtask

  task automatic expected_stream(input int u, output logic [7:0] q [$]);
    logic [7:0] x;
    q = {};
    x = 8'h00;
    for (int i = first_of(u); i <= last_of(u); i++) begin
      q.push_back(regs[i]);
      x = x ^ regs[i];
    end
`ifdef REGDUMP_CSUM_EN
    q.push_back(x);
`endif
  endtask

  task automatic check_reset_vals(input string name);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (obs_op[u] !== {3'b000, 4'(first_of(u))} || obs_data[u] !== 8'h00 ||
          obs_valid[u] !== 1'b0 || obs_busy[u] !== 1'b0 || obs_done[u] !== 1'b0) begin
        errors++;
        $display("FAIL %s u%0d: op=%h data=%h valid=%b busy=%b done=%b, required op=%h data=00 valid=0 busy=0 done=0",
                 name, u, obs_op[u], obs_data[u], obs_valid[u], obs_busy[u], obs_done[u], first_of(u));
      end
    end
  endtask

  // mode 0: ready high; 1: ready low 5 cycles when byte stall_byte is offered; 2: random ready
  task automatic run_dump(input int u, input int mode, input int stall_byte, input string name,
                          output int done_k, output int stall_total);
    logic [7:0] exp_q [$];
    logic [7:0] prev_d;
    logic [6:0] prev_op;
    logic       v, r, prev_v, prev_r;
    int k, got, stall, n;
    expected_stream(u, exp_q);
    n = exp_q.size();
    start_s[u] = 1'b1;
    ready_s[u] = 1'b1;
    @(posedge clk); #1;
    start_s[u] = 1'b0;
    k = 1; got = 0; stall = 0; stall_total = 0; done_k = -1;
    prev_v = 1'b0; prev_r = 1'b1; prev_d = 8'h00; prev_op = 7'h00;
    while (k < 400 && done_k < 0) begin
      v = obs_valid[u];
      checks++;
      if (obs_op[u][6:4] !== 3'b000) begin
        errors++;
        $display("FAIL %s op_hi: got %b required 000", name, obs_op[u][6:4]);
      end
      if (k == 1) begin
        checks++;
        if (obs_busy[u] !== 1'b1 || obs_op[u][3:0] !== 4'(first_of(u))) begin
          errors++;
          $display("FAIL %s start_resp: busy=%b idx=%h required busy=1 idx=%h",
                   name, obs_busy[u], obs_op[u][3:0], first_of(u));
        end
      end
      if (k == 2 && mode == 0) begin
        checks++;
        if (v !== 1'b1) begin
          errors++;
          $display("FAIL %s first_valid: got %b required 1", name, v);
        end
      end
      if (prev_v && !prev_r) begin
        checks++;
        if (v !== 1'b1 || obs_data[u] !== prev_d || obs_op[u] !== prev_op) begin
          errors++;
          $display("FAIL %s stall_hold: valid=%b data=%h op=%h required valid=1 data=%h op=%h",
                   name, v, obs_data[u], obs_op[u], prev_d, prev_op);
        end
      end
      if (obs_done[u] === 1'b1) begin
        done_k = k;
        checks++;
        if (got != n || obs_busy[u] !== 1'b0) begin
          errors++;
          $display("FAIL %s done_state: bytes=%0d busy=%b required bytes=%0d busy=0",
                   name, got, obs_busy[u], n);
        end
      end else begin
        if (mode == 2) r = 1'($urandom_range(0, 1));
        else if (mode == 1 && got == stall_byte && v && stall < 5) begin
          r = 1'b0; stall++;
        end else r = 1'b1;
        if (!r && v) stall_total++;
        ready_s[u] = r;
        if (v && r) begin
          checks++;
          if (got >= n || obs_data[u] !== exp_q[got]) begin
            errors++;
            $display("FAIL %s byte%0d: got %h required %h", name, got, obs_data[u],
                     (got < n) ? exp_q[got] : 8'hxx);
          end
          got++;
        end
        prev_v = v; prev_r = r; prev_d = obs_data[u]; prev_op = obs_op[u];
        @(posedge clk); #1;
        k++;
      end
    end
    ready_s[u] = 1'b1;
    if (done_k < 0) begin
      checks++; errors++;
      $display("FAIL %s timeout: no done after %0d cycles, required done", name, k);
    end
  endtask

  task automatic check_latency(input string name, input int u, input int done_k, input int extra);
    int nreg, expk;
    nreg = last_of(u) - first_of(u) + 1;
    expk = 2 * nreg + 1 + extra;
`ifdef REGDUMP_CSUM_EN
    expk = expk + 1;
`endif
    checks++;
    if (done_k != expk) begin
      errors++;
      $display("FAIL %s latency: done after %0d cycles required %0d", name, done_k, expk);
    end
  endtask

  task automatic test_reset();
    check_reset_vals("reset");
  endtask

  task automatic test_default_dump();
    int dk, st;
    run_dump(0, 0, 0, "default", dk, st);
    check_latency("default", 0, dk, 0);
    @(posedge clk); #1;
    checks++;
    if (obs_done[0] !== 1'b0 || obs_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL default post_done: done=%b busy=%b required 0 0", obs_done[0], obs_busy[0]);
    end
  endtask

  task automatic test_range();
    int dk, st;
    run_dump(1, 0, 0, "range5_10", dk, st);
    check_latency("range5_10", 1, dk, 0);
  endtask

  task automatic test_backpressure();
    int dk, st;
    run_dump(0, 1, 1, "backpressure", dk, st);
    check_latency("backpressure", 0, dk, st);
  endtask

  task automatic test_random();
    int dk, st;
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 16; i++) regs[i] = 8'($urandom);
      run_dump(0, 2, 0, "random_u0", dk, st);
      check_latency("random_u0", 0, dk, st);
      run_dump(1, 2, 0, "random_u1", dk, st);
      check_latency("random_u1", 1, dk, st);
    end
    init_regs();
  endtask

  task automatic test_start_while_busy();
    int dones, bytes;
    dones = 0; bytes = 0;
    ready_s[0] = 1'b1;
    start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    for (int k = 1; k < 40; k++) begin
      if (obs_done[0] === 1'b1) dones++;
      if (obs_valid[0] === 1'b1) bytes++;
      start_s[0] = (k == 3 || k == 6) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
    end
    start_s[0] = 1'b0;
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL busy_start dones: got %0d required 1", dones);
    end
    checks++;
`ifdef REGDUMP_CSUM_EN
    if (bytes != 5) begin
      errors++;
      $display("FAIL busy_start bytes: got %0d required 5", bytes);
    end
`else
    if (bytes != 4) begin
      errors++;
      $display("FAIL busy_start bytes: got %0d required 4", bytes);
    end
`endif
  endtask

  task automatic test_reset_mid_dump();
    int got, k;
    got = 0; k = 0;
    ready_s[0] = 1'b1;
    start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    while (got < 2 && k < 50) begin
      if (obs_valid[0] === 1'b1) got++;
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (got < 2) begin
      errors++;
      $display("FAIL midreset progress: bytes %0d required 2", got);
    end
    rst_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (obs_done[0] !== 1'b0 || obs_valid[0] !== 1'b0) begin
        errors++;
        $display("FAIL midreset hold: done=%b valid=%b required 0 0", obs_done[0], obs_valid[0]);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int dk, st, k;
    run_dump(0, 0, 0, "b2b_first", dk, st);
    start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (obs_valid[0] !== 1'b1 || obs_data[0] !== 8'h02) begin
      errors++;
      $display("FAIL b2b restart: valid=%b data=%h required valid=1 data=02", obs_valid[0], obs_data[0]);
    end
    k = 0;
    while (obs_done[0] !== 1'b1 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (obs_done[0] !== 1'b1) begin
      errors++;
      $display("FAIL b2b drain: no done, required done");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    start_s[0] = 1'b0; start_s[1] = 1'b0;
    ready_s[0] = 1'b1; ready_s[1] = 1'b1;
    init_regs();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_default_dump();
    test_range();
    test_backpressure();
    test_random();
    test_start_while_busy();
    test_reset_mid_dump();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
